trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 130 +++++++++++++
 tb/tb_trap_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap controller: picks one trap/mret/interrupt event per cycle and redirects fetch to its target.
// Latency: save/enter/restore pulses come in the same cycle as the event; redirect/flush come one cycle later.
// Backpressure: interrupts wait while ex_busy_i is high; all event inputs are ignored during the redirect cycle.
// Ports: clk_i/rst_n_i; exception, mret, irq and CSR inputs; save/enter/restore pulses; redirect/flush/stall.
module trap_ctrl #(
    parameter bit VECTORED = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        exc_ex_valid_i,
    input  logic [4:0]  exc_ex_cause_i,
    input  logic        exc_id_valid_i,
    input  logic [4:0]  exc_id_cause_i,
    input  logic        mret_i,
    input  logic [2:0]  irq_i,          // {meip, mtip, msip}
    input  logic [2:0]  irq_en_i,       // {mie[11], mie[7], mie[3]}
    input  logic        mstatus_mie_i,
    input  logic        ex_busy_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        save_pc_ex_o,
    output logic        save_pc_id_o,
    output logic [4:0]  cause_o,
    output logic        intr_o,
    output logic        trap_enter_o,
    output logic        mret_restore_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        stall_o
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  irq_q;
    logic [31:0] target_q, target_d;

    logic [2:0]  pending;
    logic        irq_hit;
    logic [4:0]  irq_cause;
    logic [31:0] base_pc;
    logic [31:0] irq_pc;

    assign pending = irq_q & irq_en_i & {3{mstatus_mie_i}};
    assign irq_hit = |pending;
    assign base_pc = {mtvec_i[31:2], 2'b00};

    // Fixed interrupt priority: external > software > timer.
    always_comb begin
        irq_cause = 5'd0;
        if (pending[2]) begin
            irq_cause = 5'd11;
        end else if (pending[0]) begin
            irq_cause = 5'd3;
        end else if (pending[1]) begin
            irq_cause = 5'd7;
        end
    end

    // Vector offset is 4*cause; the sum wraps naturally at 32 bits.
    assign irq_pc = VECTORED ? (base_pc + {25'd0, irq_cause, 2'b00}) : base_pc;

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        save_pc_ex_o   = 1'b0;
        save_pc_id_o   = 1'b0;
        cause_o        = 5'd0;
        intr_o         = 1'b0;
        trap_enter_o   = 1'b0;
        mret_restore_o = 1'b0;
        redirect_o     = 1'b0;
        flush_o        = 1'b0;
        stall_o        = 1'b0;

        if (state_q == REDIRECT) begin
            // Anything presented now belongs to instructions being flushed.
            redirect_o = 1'b1;
            flush_o    = 1'b1;
            stall_o    = 1'b1;
            state_d    = IDLE;
        end else if (rst_n_i) begin
            // Pulses are suppressed while reset is held so the CSR block sees nothing spurious.
            if (exc_ex_valid_i) begin
                save_pc_ex_o = 1'b1;
                cause_o      = exc_ex_cause_i;
                trap_enter_o = 1'b1;
                target_d     = base_pc;
                state_d      = REDIRECT;
            end else if (mret_i) begin
                mret_restore_o = 1'b1;
                target_d       = mepc_i;
                state_d        = REDIRECT;
            end else if (exc_id_valid_i) begin
                save_pc_id_o = 1'b1;
                cause_o      = exc_id_cause_i;
                trap_enter_o = 1'b1;
                target_d     = base_pc;
                state_d      = REDIRECT;
            end else if (irq_hit && !ex_busy_i) begin
                // Interrupt is taken on the ID instruction so the EX op can retire first.
                save_pc_id_o = 1'b1;
                cause_o      = irq_cause;
                intr_o       = 1'b1;
                trap_enter_o = 1'b1;
                target_d     = irq_pc;
                state_d      = REDIRECT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            irq_q    <= 3'b000;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_i;
            target_q <= target_d;
        end
    end

    assign redirect_pc_o = target_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        exc_ex_valid_i;
    logic [4:0]  exc_ex_cause_i;
    logic        exc_id_valid_i;
    logic [4:0]  exc_id_cause_i;
    logic        mret_i;
    logic [2:0]  irq_i;
    logic [2:0]  irq_en_i;
    logic        mstatus_mie_i;
    logic        ex_busy_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        save_pc_ex_o;
    logic        save_pc_id_o;
    logic [4:0]  cause_o;
    logic        intr_o;
    logic        trap_enter_o;
    logic        mret_restore_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;

    trap_ctrl #(.VECTORED(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .exc_ex_valid_i (exc_ex_valid_i),
        .exc_ex_cause_i (exc_ex_cause_i),
        .exc_id_valid_i (exc_id_valid_i),
        .exc_id_cause_i (exc_id_cause_i),
        .mret_i         (mret_i),
        .irq_i          (irq_i),
        .irq_en_i       (irq_en_i),
        .mstatus_mie_i  (mstatus_mie_i),
        .ex_busy_i      (ex_busy_i),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .save_pc_ex_o   (save_pc_ex_o),
        .save_pc_id_o   (save_pc_id_o),
        .cause_o        (cause_o),
        .intr_o         (intr_o),
        .trap_enter_o   (trap_enter_o),
        .mret_restore_o (mret_restore_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .flush_o        (flush_o),
        .stall_o        (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Control outputs packed as {save_ex, save_id, trap_enter, mret_restore, redirect, flush, stall}.
    function automatic logic [6:0] ctl();
        return {save_pc_ex_o, save_pc_id_o, trap_enter_o, mret_restore_o,
                redirect_o, flush_o, stall_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        rst_n_i = 1'b0;
        exc_ex_valid_i = 1'b0; exc_ex_cause_i = 5'd0;
        exc_id_valid_i = 1'b0; exc_id_cause_i = 5'd0;
        mret_i = 1'b0; irq_i = 3'b000; irq_en_i = 3'b111;
        mstatus_mie_i = 1'b1; ex_busy_i = 1'b0;
        mtvec_i = 32'h0000_0100; mepc_i = 32'h0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_ctl", {25'd0, ctl()}, 32'h0);
        chk("rst_pc", redirect_pc_o, 32'h0);
        cyc(); rst_n_i = 1'b1;

        // EX exception, first cycle after reset release
        cyc(); exc_ex_valid_i = 1'b1; exc_ex_cause_i = 5'd2; #1;
        chk("exc_ex_ctl", {25'd0, ctl()}, 32'b1010000);
        chk("exc_ex_cause", {27'd0, cause_o}, 32'd2);
        chk("exc_ex_intr", {31'd0, intr_o}, 32'd0);
        cyc(); exc_ex_valid_i = 1'b0; #1;
        chk("exc_ex_redir_ctl", {25'd0, ctl()}, 32'b0000111);
        chk("exc_ex_redir_pc", redirect_pc_o, 32'h100);
        cyc(); #1;
        chk("exc_ex_back_idle", {25'd0, ctl()}, 32'h0);
        chk("exc_ex_pc_hold", redirect_pc_o, 32'h100);

        // EX beats ID; held ID event is ignored in REDIRECT, taken afterwards; mtvec low bits masked
        mtvec_i = 32'h0000_0103;
        cyc(); exc_ex_valid_i = 1'b1; exc_ex_cause_i = 5'd2;
        exc_id_valid_i = 1'b1; exc_id_cause_i = 5'd3; #1;
        chk("both_ctl", {25'd0, ctl()}, 32'b1010000);
        chk("both_cause", {27'd0, cause_o}, 32'd2);
        cyc(); exc_ex_valid_i = 1'b0; #1;
        chk("id_in_redir_ctl", {25'd0, ctl()}, 32'b0000111);
        chk("masked_pc", redirect_pc_o, 32'h100);
        cyc(); #1;
        chk("id_after_ctl", {25'd0, ctl()}, 32'b0110000);
        chk("id_after_cause", {27'd0, cause_o}, 32'd3);
        cyc(); exc_id_valid_i = 1'b0; #1;
        chk("id_redir_ctl", {25'd0, ctl()}, 32'b0000111);

        // MRET, and MRET beats a simultaneous ID exception
        cyc(); mret_i = 1'b1; mepc_i = 32'h8000_0040;
        exc_id_valid_i = 1'b1; exc_id_cause_i = 5'd4; #1;
        chk("mret_ctl", {25'd0, ctl()}, 32'b0001000);
        cyc(); mret_i = 1'b0; exc_id_valid_i = 1'b0; #1;
        chk("mret_redir_ctl", {25'd0, ctl()}, 32'b0000111);
        chk("mret_pc", redirect_pc_o, 32'h8000_0040);

        // Vectored external interrupt (MEI over MTI)
        mtvec_i = 32'h0000_0200;
        cyc(); irq_i = 3'b110; #1;
        chk("irq_not_yet", {25'd0, ctl()}, 32'h0);
        cyc(); irq_i = 3'b000; #1;
        chk("mei_ctl", {25'd0, ctl()}, 32'b0110000);
        chk("mei_cause", {27'd0, cause_o}, 32'd11);
        chk("mei_intr", {31'd0, intr_o}, 32'd1);
        cyc(); #1;
        chk("mei_pc", redirect_pc_o, 32'h22C);
        cyc(); #1;
        chk("irq_cleared", {25'd0, ctl()}, 32'h0);

        // MSI beats MTI
        cyc(); irq_i = 3'b011;
        cyc(); irq_i = 3'b000; #1;
        chk("msi_cause", {27'd0, cause_o}, 32'd3);
        cyc(); #1;
        chk("msi_pc", redirect_pc_o, 32'h20C);

        // ID exception beats an interrupt, intr stays low
        cyc(); irq_i = 3'b100;
        cyc(); exc_id_valid_i = 1'b1; exc_id_cause_i = 5'd2; irq_i = 3'b000; #1;
        chk("id_vs_irq_cause", {27'd0, cause_o}, 32'd2);
        chk("id_vs_irq_intr", {31'd0, intr_o}, 32'd0);
        cyc(); exc_id_valid_i = 1'b0; #1;
        chk("id_vs_irq_pc", redirect_pc_o, 32'h200);

        // Timer interrupt held off by ex_busy for 4 cycles
        cyc(); irq_i = 3'b010; ex_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("busy_hold", {25'd0, ctl()}, 32'h0);
        end
        cyc(); ex_busy_i = 1'b0; #1;
        chk("mti_ctl", {25'd0, ctl()}, 32'b0110000);
        chk("mti_cause", {27'd0, cause_o}, 32'd7);
        cyc(); irq_i = 3'b000; #1;
        chk("mti_pc", redirect_pc_o, 32'h21C);

        // Global disable: interrupt never taken, but exceptions still are (even while busy)
        cyc(); mstatus_mie_i = 1'b0; irq_i = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("mie_off", {25'd0, ctl()}, 32'h0);
        end
        cyc(); ex_busy_i = 1'b1; exc_ex_valid_i = 1'b1; exc_ex_cause_i = 5'd5; #1;
        chk("exc_busy_ctl", {25'd0, ctl()}, 32'b1010000);
        chk("exc_busy_cause", {27'd0, cause_o}, 32'd5);
        cyc(); exc_ex_valid_i = 1'b0; ex_busy_i = 1'b0; irq_i = 3'b000;

        // Reset asserted during REDIRECT
        cyc(); #1;
        cyc(); mstatus_mie_i = 1'b1; exc_ex_valid_i = 1'b1; exc_ex_cause_i = 5'd1;
        cyc(); exc_ex_valid_i = 1'b0; rst_n_i = 1'b0; #1;
        chk("rst_in_redir_ctl", {25'd0, ctl()}, 32'b0000111);
        cyc(); #1;
        chk("after_rst_ctl", {25'd0, ctl()}, 32'h0);
        chk("after_rst_pc", redirect_pc_o, 32'h0);
        cyc(); rst_n_i = 1'b1; #1;
        chk("post_rst_idle", {25'd0, ctl()}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
